// File: rtl/ddr_arb_pkg.sv
// Shared types and fixed widths for the DDR request arbiter.
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CMD,
        WDATA,
        RDATA
    } arb_state_t;

    // Requester index width, sized for the largest supported NUM_REQ (8).
    localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to bit 0.
module rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] ge_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick_src;

    // Requests at or above ptr take priority; otherwise wrap to the lowest set bit.
    always_comb begin
        ge_mask  = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
        masked   = req & ge_mask;
        pick_src = (|masked) ? masked : req;
        onehot   = pick_src & (~pick_src + NUM_REQ'(1));
        found    = |req;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter sharing one DDR burst command/data port among NUM_REQ requesters.
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned LEN_W   = 8
) (
    input  logic                      core_clk,
    input  logic                      ddr_rstn,
    input  logic                      ddr_init_done,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_wvalid,
    output logic [NUM_REQ-1:0]        req_wready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      m_cmd_valid,
    input  logic                      m_cmd_ready,
    output logic                      m_cmd_we,
    output logic [ADDR_W-1:0]         m_cmd_addr,
    output logic [LEN_W-1:0]          m_cmd_len,
    output logic [DATA_W-1:0]         m_wdata,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic                      m_wlast,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_rvalid,
    input  logic                      m_rlast,
    output logic                      err_flag
);

    arb_state_t state, state_nxt;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx_r;
    logic [NUM_REQ-1:0] sel_oh;
    logic [LEN_W-1:0]   beat_cnt;
    logic               rd_fin;
    logic               cnt_at_len;

    logic               pick_found;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_we;
    logic [ADDR_W-1:0]  pick_addr;
    logic [LEN_W-1:0]   pick_len;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .found  (pick_found),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        pick_we   = 1'b0;
        pick_addr = '0;
        pick_len  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_we   = req_we[i];
                pick_addr = req_addr[i*ADDR_W +: ADDR_W];
                pick_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign cnt_at_len = (beat_cnt == m_cmd_len);

    always_ff @(posedge core_clk) begin
        if (!ddr_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        m_cmd_valid = 1'b0;
        gnt         = '0;
        m_wdata     = '0;
        m_wvalid    = 1'b0;
        m_wlast     = 1'b0;
        req_wready  = '0;
        case (state)
            IDLE: begin
                // Hold off while the final read beat is still being forwarded.
                if (ddr_init_done && (|req) && !rd_fin) begin
                    state_nxt = ARB;
                end
            end
            ARB: begin
                state_nxt = pick_found ? CMD : IDLE;
            end
            CMD: begin
                m_cmd_valid = 1'b1;
                if (m_cmd_ready) begin
                    gnt       = sel_oh;
                    state_nxt = m_cmd_we ? WDATA : RDATA;
                end
            end
            WDATA: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (sel_oh[i]) begin
                        m_wdata  = req_wdata[i*DATA_W +: DATA_W];
                        m_wvalid = req_wvalid[i];
                    end
                end
                m_wlast    = cnt_at_len;
                req_wready = m_wready ? sel_oh : '0;
                if (m_wvalid && m_wready && cnt_at_len) begin
                    state_nxt = IDLE;
                end
            end
            RDATA: begin
                if (m_rvalid && cnt_at_len) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!ddr_rstn) begin
            rr_ptr     <= '0;
            idx_r      <= '0;
            sel_oh     <= '0;
            beat_cnt   <= '0;
            rd_fin     <= 1'b0;
            done       <= '0;
            req_rvalid <= '0;
            req_rdata  <= '0;
            m_cmd_we   <= 1'b0;
            m_cmd_addr <= '0;
            m_cmd_len  <= '0;
            err_flag   <= 1'b0;
        end else begin
            done       <= '0;
            req_rvalid <= '0;
            rd_fin     <= 1'b0;
            case (state)
                ARB: begin
                    if (pick_found) begin
                        idx_r      <= pick_idx;
                        sel_oh     <= pick_oh;
                        m_cmd_we   <= pick_we;
                        m_cmd_addr <= pick_addr;
                        m_cmd_len  <= pick_len;
                    end
                end
                CMD: begin
                    if (m_cmd_ready) begin
                        rr_ptr   <= (idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : idx_r + 1'b1;
                        beat_cnt <= '0;
                    end
                end
                WDATA: begin
                    if (m_wvalid && m_wready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (cnt_at_len) begin
                            done <= sel_oh;
                        end
                    end
                end
                RDATA: begin
                    if (m_rvalid) begin
                        beat_cnt   <= beat_cnt + 1'b1;
                        req_rvalid <= sel_oh;
                        req_rdata  <= m_rdata;
                        if (m_rlast != cnt_at_len) begin
                            err_flag <= 1'b1;
                        end
                        if (cnt_at_len) begin
                            rd_fin <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Read data outside a read burst is dropped and flagged.
            if (m_rvalid && (state != RDATA)) begin
                err_flag <= 1'b1;
            end
            if (rd_fin) begin
                done <= sel_oh;
            end
        end
    end

endmodule
